// File: rtl/in_service_control.sv
// In-service register and INTA acknowledge sequencer for an 8-level interrupt controller.
// Tracks serviced levels, handles EOI commands and keeps the rotating lowest-priority level.
module in_service_control (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] interrupt_to_service,
  input  logic       inta_n,
  input  logic       auto_eoi_mode,
  input  logic       eoi_cmd,
  input  logic       eoi_specific,
  input  logic [2:0] eoi_level,
  input  logic       rotate_on_eoi,
  input  logic       set_priority_cmd,
  input  logic [2:0] priority_level,
  output logic [7:0] in_service_register,
  output logic [7:0] rotated_in_service,
  output logic [2:0] priority_rotate,
  output logic [2:0] vector_level,
  output logic       vector_valid,
  output logic       end_of_acknowledge,
  output logic [1:0] debug_state
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACK1_LOW  = 2'd1,
    ACK1_HIGH = 2'd2,
    ACK2_LOW  = 2'd3
  } state_t;

  state_t     r_state;
  logic       r_inta_prev;
  logic       r_spurious;
  logic [7:0] r_isr;
  logic [2:0] r_pri;
  logic [2:0] r_vec_level;
  logic       r_vec_valid;
  logic       r_eoa;

  logic       w_fall;
  logic       w_rise;
  logic       w_ack_start;
  logic       w_ack_done;
  logic       w_auto_clear;
  logic [2:0] w_req_level;
  logic [7:0] w_rot;
  logic       w_ns_found;
  logic [2:0] w_ns_idx;
  logic [2:0] w_ns_level;
  logic [7:0] w_clr_mask;
  logic [7:0] w_set_mask;
  logic [7:0] w_isr_next;
  logic [2:0] w_pri_next;

  assign w_fall       = ~inta_n & r_inta_prev;
  assign w_rise       = inta_n & ~r_inta_prev;
  assign w_ack_start  = (r_state == IDLE) & w_fall;
  assign w_ack_done   = (r_state == ACK2_LOW) & w_rise;
  assign w_auto_clear = w_ack_done & auto_eoi_mode & ~r_spurious;

  // A spurious (all-zero) request falls through to level 7.
  always_comb begin
    w_req_level = 3'd7;
    for (int i = 7; i >= 0; i--) begin
      if (interrupt_to_service[i]) w_req_level = 3'(i);
    end
  end

  always_comb begin
    w_rot = 8'h00;
    for (int i = 0; i < 8; i++) begin
      w_rot[i] = r_isr[3'(i) + r_pri + 3'd1];
    end
  end

  always_comb begin
    w_ns_found = 1'b0;
    w_ns_idx   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_ns_found = 1'b1;
        w_ns_idx   = 3'(i);
      end
    end
  end

  assign w_ns_level = w_ns_idx + r_pri + 3'd1;

  // EOI acts on the pre-set ISR; a bit set by a same-cycle acknowledge is ORed in afterwards.
  always_comb begin
    w_clr_mask = 8'h00;
    if (eoi_cmd) begin
      if (eoi_specific)    w_clr_mask[eoi_level]  = 1'b1;
      else if (w_ns_found) w_clr_mask[w_ns_level] = 1'b1;
    end
    if (w_auto_clear) w_clr_mask[r_vec_level] = 1'b1;
  end

  assign w_set_mask = w_ack_start ? interrupt_to_service : 8'h00;
  assign w_isr_next = (r_isr & ~w_clr_mask) | w_set_mask;

  always_comb begin
    w_pri_next = r_pri;
    if (w_auto_clear && rotate_on_eoi) w_pri_next = r_vec_level;
    if (eoi_cmd && rotate_on_eoi) begin
      if (eoi_specific)    w_pri_next = eoi_level;
      else if (w_ns_found) w_pri_next = w_ns_level;
    end
    if (set_priority_cmd) w_pri_next = priority_level;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_inta_prev <= 1'b1;
      r_spurious  <= 1'b0;
      r_isr       <= 8'h00;
      r_pri       <= 3'd7;
      r_vec_level <= 3'd0;
      r_vec_valid <= 1'b0;
      r_eoa       <= 1'b0;
    end else begin
      r_inta_prev <= inta_n;
      r_isr       <= w_isr_next;
      r_pri       <= w_pri_next;
      r_eoa       <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_fall) begin
            r_state     <= ACK1_LOW;
            r_vec_level <= w_req_level;
            r_spurious  <= ~|interrupt_to_service;
          end
        end
        ACK1_LOW: begin
          if (w_rise) r_state <= ACK1_HIGH;
        end
        ACK1_HIGH: begin
          if (w_fall) begin
            r_state     <= ACK2_LOW;
            r_vec_valid <= 1'b1;
          end
        end
        ACK2_LOW: begin
          if (w_rise) begin
            r_state     <= IDLE;
            r_vec_valid <= 1'b0;
            r_eoa       <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_service_register = r_isr;
  assign rotated_in_service  = w_rot;
  assign priority_rotate     = r_pri;
  assign vector_level        = r_vec_level;
  assign vector_valid        = r_vec_valid;
  assign end_of_acknowledge  = r_eoa;
  assign debug_state         = r_state;

endmodule

// File: doc/in_service_control.md
IN_SERVICE_CONTROL -- requirements
Module: in_service_control

Interface
REQ-001 The block SHALL use one clock and an asynchronous active-low reset, with ports listed clock first, then reset.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 interrupt_to_service  input  8  one-hot winning request from the resolver; all-zero means no request.
REQ-005 inta_n  input  1  interrupt acknowledge, active-low, already synchronised to clk.
REQ-006 auto_eoi_mode  input  1  when 1, clear the serviced bit at the end of the acknowledge sequence.
REQ-007 eoi_cmd  input  1  one-cycle EOI command strobe.
REQ-008 eoi_specific  input  1  with eoi_cmd: 1 = specific EOI, 0 = non-specific EOI.
REQ-009 eoi_level  input  3  IR level targeted by a specific EOI.
REQ-010 rotate_on_eoi  input  1  with eoi_cmd, or in auto-EOI: rotate priority to the cleared level.
REQ-011 set_priority_cmd  input  1  one-cycle strobe to load priority_rotate.
REQ-012 priority_level  input  3  value loaded by set_priority_cmd.
REQ-013 in_service_register  output  8  registered ISR, bit n = IRn in service.
REQ-014 rotated_in_service  output  8  combinational, ISR rotated so bit 0 is the highest-priority level.
REQ-015 priority_rotate  output  3  registered lowest-priority level.
REQ-016 vector_level  output  3  registered IR level of the current acknowledge.
REQ-017 vector_valid  output  1  registered, high during the second INTA low phase.
REQ-018 end_of_acknowledge  output  1  registered one-cycle pulse when the sequence completes.

Function
REQ-019 An inta_n falling edge SHALL be a cycle where inta_n=0 and its registered previous value is 1; a rising edge is the inverse.
REQ-020 The FSM SHALL have the states IDLE, ACK1_LOW, ACK1_HIGH and ACK2_LOW.
REQ-021 IDLE --fall--> ACK1_LOW: in the same edge, ISR |= interrupt_to_service and vector_level <= encode(interrupt_to_service).
REQ-022 When interrupt_to_service is 0 at that edge (spurious request), ISR SHALL be unchanged and vector_level SHALL be 7.
REQ-023 ACK1_LOW --rise--> ACK1_HIGH.
REQ-024 ACK1_HIGH --fall--> ACK2_LOW, and vector_valid <= 1.
REQ-025 ACK2_LOW --rise--> IDLE: vector_valid <= 0 and end_of_acknowledge <= 1 for exactly one cycle.
REQ-026 On the ACK2_LOW rise edge with auto_eoi_mode=1 and a non-spurious request, the block SHALL clear ISR bit vector_level.
REQ-027 If rotate_on_eoi=1 on that same edge, priority_rotate SHALL be set to vector_level.
REQ-028 rotated_in_service[i] SHALL equal ISR[(i + priority_rotate + 1) mod 8].
REQ-029 Non-specific EOI SHALL clear the ISR bit at the lowest set index of rotated_in_service, mapped back to its IR level L.
REQ-030 Non-specific EOI with rotate_on_eoi=1 SHALL also set priority_rotate <= L.
REQ-031 Non-specific EOI with ISR=0 SHALL change nothing.
REQ-032 Specific EOI SHALL clear ISR[eoi_level], even if that bit is already 0.
REQ-033 Specific EOI with rotate_on_eoi=1 SHALL also set priority_rotate <= eoi_level.
REQ-034 Same-cycle ISR set and EOI: the EOI SHALL be evaluated on the pre-set ISR, then the set bit is ORed in, so the new bit survives.
REQ-035 set_priority_cmd SHALL load priority_rotate <= priority_level and SHALL take precedence over any same-cycle rotation.
REQ-036 inta_n edges that do not match the current state's expected edge SHALL be ignored.
REQ-037 EOI and set-priority commands SHALL be accepted in every FSM state.

Reset
REQ-038 While reset_n=0, asynchronously: ISR=0, priority_rotate=7, vector_level=0, vector_valid=0, end_of_acknowledge=0, state=IDLE, inta_n history register=1.
REQ-039 Reset asserted mid-acknowledge SHALL abort the sequence with no end_of_acknowledge pulse.

Verification
REQ-040 Normal ack: interrupt_to_service=8'h08 and two INTA pulses, auto_eoi_mode=0 -> ISR=8'h08, vector_level=3, vector_valid high in the second low phase, one end_of_acknowledge pulse.
REQ-041 Auto-EOI with rotation: request=8'h20, auto_eoi_mode=1, rotate_on_eoi=1 -> after the second rise, ISR=0 and priority_rotate=5; rotated_in_service maps bit0 to IR6.
REQ-042 Non-specific EOI: ISR=8'h12, priority_rotate=7 -> clears IR1 (ISR=8'h10); repeated with priority_rotate=1 -> clears IR4 (ISR=8'h02).
REQ-043 Specific EOI plus set-priority: eoi_level=4 with rotate_on_eoi=1 and set_priority_cmd with priority_level=2 in the same cycle -> ISR bit4 clears and priority_rotate=2.
REQ-044 Spurious ack: interrupt_to_service=0 at the first INTA fall -> vector_level=7, ISR unchanged.
REQ-045 Reset mid-ack: reset_n low in ACK1_HIGH -> all outputs at reset values, and the next INTA fall is treated as a first pulse.
